multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
Main control FSM for the multi-cycle RV32 datapath. It replaces the per-instruction combinational decoder and sequences one shared memory, ALU and register file across FETCH/DECODE/EXEC/MEM/WB steps. It supports R-type, lw, sw, beq and addi, and stalls on a memory ready handshake. It sits between the instruction register's opcode field and all datapath mux selects and write enables.

Parameters:
- OPW, 7, opcode width.
- ALUOPW, 2, aluop width (00 add, 01 sub/compare, 10 funct-decoded, 11 I-type funct-decoded).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  OPW  IR[6:0]; valid from DECODE onward.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- pcwrite  out  1  unconditional PC load.
- pcwritecond  out  1  PC load if zero.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- memread  out  1  memory read request.
- memwrite  out  1  memory write request.
- irwrite  out  1  instruction register load.
- memtoreg  out  1  writeback select: 1 = MDR.
- pcsource  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target.
- aluop  out  ALUOPW  ALU control class.
- alusrca  out  1  0 = PC, 1 = rs1.
- alusrcb  out  2  00 rs2, 01 constant 4, 10 immediate, 11 branch offset.
- regwrite  out  1  register file write enable.
- instr_done  out  1  one-cycle pulse on the final cycle of each instruction.
- illegal  out  1  sticky; set on an unknown opcode in DECODE.

Behaviour:
- Moore FSM on a state register that is async-cleared to FETCH. Outputs decode from state; strobes marked (r) are additionally ANDed with mem_ready.
- Default for every output is 0 / 00. Immediately after reset, outputs equal FETCH values and illegal = 0.
- FETCH: memread = 1, iord = 0, alusrca = 0, alusrcb = 01, aluop = 00, pcsource = 00, irwrite (r), pcwrite (r). Holds while mem_ready = 0, then goes to DECODE.
- DECODE: alusrca = 0, alusrcb = 11, aluop = 00 (precompute branch target).
  - Next state by opcode: 0x03/0x23 → MEMADR, 0x33 → EXEC, 0x13 → EXECI, 0x63 → BRANCH.
  - Any other opcode: set illegal, pulse instr_done, go to FETCH.
- MEMADR: alusrca = 1, alusrcb = 10, aluop = 00. Next is MEMRD if opcode = 0x03, else MEMWR.
- MEMRD: memread = 1, iord = 1. Holds until mem_ready, then goes to MEMWB.
- MEMWB: regwrite = 1, memtoreg = 1, instr_done = 1. Next is FETCH.
- MEMWR: memwrite = 1, iord = 1, instr_done (r). Holds until mem_ready, then goes to FETCH.
- EXEC: alusrca = 1, alusrcb = 00, aluop = 10. Next is ALUWB.
- EXECI: alusrca = 1, alusrcb = 10, aluop = 11. Next is ALUWB.
- ALUWB: regwrite = 1, memtoreg = 0, instr_done = 1. Next is FETCH.
- BRANCH: alusrca = 1, alusrcb = 00, aluop = 01, pcwritecond = 1, pcsource = 01, instr_done = 1. Next is FETCH.
- Latency with zero-wait memory:
  - beq: 3 cycles.
  - R-type, addi, sw: 4 cycles.
  - lw: 5 cycles.
  - Each memory wait cycle adds exactly 1.
- Memory request signals (memread/memwrite/iord) stay stable throughout a stall.
- Never drives memread and memwrite together. Never drives regwrite together with any memory request.
- illegal clears only on reset.
- Reset mid-instruction: all outputs drop to FETCH values asynchronously. No partial writes complete after the reset edge.
- Unreachable state encodings recover to FETCH on the next edge.

Optional Feature:
- Macro: MC_JAL_EN.
- Defined:
  - opcode 0x6F in DECODE → JAL state.
  - JAL: alusrca = 0, alusrcb = 01, aluop = 00, regwrite = 1, memtoreg = 0, pcwrite = 1, pcsource = 10, instr_done = 1. Next is FETCH. jal takes 3 cycles.
- Undefined: 0x6F is illegal like any unknown opcode.

Decomposition:
- Package mc_pkg:
  - State enum (FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, EXECI, ALUWB, BRANCH, JAL).
  - Opcode constants OP_RTYPE, OP_LOAD, OP_STORE, OP_BRANCH, OP_IMM, OP_JAL.
  - aluop, pcsource and alusrcb code constants.
- One sub-module, mc_output_decode: purely combinational, maps state and mem_ready to output strobes. The top keeps the state register and next-state logic.

Test Plan:
- Reset: rst_n low mid-MEMWR → memwrite = 0 immediately, state FETCH, memread = 1, illegal = 0.
- Zero-wait, opcode 0x33 → states FETCH, DECODE, EXEC, ALUWB; regwrite = 1 for exactly 1 cycle; aluop = 10 in EXEC; instr_done on cycle 4.
- lw (0x03) with mem_ready low for 2 cycles in both FETCH and MEMRD → 9 cycles total; irwrite pulses once; memtoreg = 1 with regwrite in MEMWB.
- beq (0x63), zero = 1 then zero = 0 → pcwritecond = 1 and pcsource = 01 in BRANCH both times; 3-cycle instruction.
- Opcode 0x7F → illegal rises after DECODE, returns to FETCH, no regwrite/memwrite; illegal stays 1 through a following addi.
- With MC_JAL_EN, opcode 0x6F → JAL with pcwrite = 1, pcsource = 10, regwrite = 1. Without the macro → illegal = 1.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle RV32 control FSM.
// MC_JAL_EN adds the JAL opcode to the legal set.
package mc_pkg;

    localparam int OPW    = 7;
    localparam int ALUOPW = 2;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        EXEC, EXECI, ALUWB, BRANCH, JAL
    } state_t;

    localparam logic [OPW-1:0] OP_RTYPE  = 7'h33;
    localparam logic [OPW-1:0] OP_LOAD   = 7'h03;
    localparam logic [OPW-1:0] OP_STORE  = 7'h23;
    localparam logic [OPW-1:0] OP_BRANCH = 7'h63;
    localparam logic [OPW-1:0] OP_IMM    = 7'h13;
    localparam logic [OPW-1:0] OP_JAL    = 7'h6F;

    localparam logic [ALUOPW-1:0] ALU_ADD    = 2'b00;
    localparam logic [ALUOPW-1:0] ALU_SUB    = 2'b01;
    localparam logic [ALUOPW-1:0] ALU_FUNCT  = 2'b10;
    localparam logic [ALUOPW-1:0] ALU_IFUNCT = 2'b11;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFF = 2'b11;

    typedef struct packed {
        logic              pcwrite;
        logic              pcwritecond;
        logic              iord;
        logic              memread;
        logic              memwrite;
        logic              irwrite;
        logic              memtoreg;
        logic [1:0]        pcsource;
        logic [ALUOPW-1:0] aluop;
        logic              alusrca;
        logic [1:0]        alusrcb;
        logic              regwrite;
        logic              instr_done;
    } ctrl_t;

    function automatic logic op_legal(input logic [OPW-1:0] op);
        case (op)
            OP_RTYPE, OP_LOAD, OP_STORE, OP_BRANCH, OP_IMM: return 1'b1;
`ifdef MC_JAL_EN
            OP_JAL: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath signal bundle; master is the control FSM side.
interface multicycle_control_if #(
    parameter int OPW    = 7,
    parameter int ALUOPW = 2
);
    logic [OPW-1:0]    opcode;
    logic              zero;
    logic              mem_ready;
    logic              pcwrite;
    logic              pcwritecond;
    logic              iord;
    logic              memread;
    logic              memwrite;
    logic              irwrite;
    logic              memtoreg;
    logic [1:0]        pcsource;
    logic [ALUOPW-1:0] aluop;
    logic              alusrca;
    logic [1:0]        alusrcb;
    logic              regwrite;
    logic              instr_done;
    logic              illegal;

    modport master (
        input  opcode, zero, mem_ready,
        output pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
               memtoreg, pcsource, aluop, alusrca, alusrcb, regwrite,
               instr_done, illegal
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
               memtoreg, pcsource, aluop, alusrca, alusrcb, regwrite,
               instr_done, illegal
    );
endinterface

// File: rtl/mc_output_decode.sv
// Moore output decode of the control state; memory-completion strobes are
// qualified by mem_ready. MC_JAL_EN enables the JAL state decode.
module mc_output_decode
    import mc_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.memread = 1'b1;
                ctrl.alusrcb = SRCB_FOUR;
                ctrl.irwrite = mem_ready;
                ctrl.pcwrite = mem_ready;
            end
            DECODE: ctrl.alusrcb = SRCB_BOFF;
            MEMADR: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
            end
            MEMRD: begin
                ctrl.memread = 1'b1;
                ctrl.iord    = 1'b1;
            end
            MEMWB: begin
                ctrl.regwrite   = 1'b1;
                ctrl.memtoreg   = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            MEMWR: begin
                ctrl.memwrite   = 1'b1;
                ctrl.iord       = 1'b1;
                ctrl.instr_done = mem_ready;
            end
            EXEC: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_RS2;
                ctrl.aluop   = ALU_FUNCT;
            end
            EXECI: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
                ctrl.aluop   = ALU_IFUNCT;
            end
            ALUWB: begin
                ctrl.regwrite   = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            BRANCH: begin
                ctrl.alusrca     = 1'b1;
                ctrl.alusrcb     = SRCB_RS2;
                ctrl.aluop       = ALU_SUB;
                ctrl.pcwritecond = 1'b1;
                ctrl.pcsource    = PCS_ALUOUT;
                ctrl.instr_done  = 1'b1;
            end
`ifdef MC_JAL_EN
            JAL: begin
                ctrl.alusrcb    = SRCB_FOUR;
                ctrl.regwrite   = 1'b1;
                ctrl.pcwrite    = 1'b1;
                ctrl.pcsource   = PCS_JUMP;
                ctrl.instr_done = 1'b1;
            end
`endif
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32 control FSM: state register, next-state logic and sticky
// illegal-opcode flag. Define MC_JAL_EN to support jal (opcode 0x6F).
module multicycle_control
    import mc_pkg::*;
#(
    parameter int OPW    = mc_pkg::OPW,
    parameter int ALUOPW = mc_pkg::ALUOPW
) (
    input  logic                clk,
    input  logic                rst_n,
    multicycle_control_if.master bus
);

    state_t state, nxt;
    ctrl_t  ctrl;
    logic   illegal_q;
    logic   bad_op;

    assign bad_op = (state == DECODE) && !op_legal(bus.opcode);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FETCH;
            illegal_q <= 1'b0;
        end else begin
            state <= nxt;
            if (bad_op) illegal_q <= 1'b1;
        end
    end

    always_comb begin
        nxt = FETCH;
        case (state)
            FETCH:  nxt = bus.mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (bus.opcode)
                    OP_LOAD, OP_STORE: nxt = MEMADR;
                    OP_RTYPE:          nxt = EXEC;
                    OP_IMM:            nxt = EXECI;
                    OP_BRANCH:         nxt = BRANCH;
`ifdef MC_JAL_EN
                    OP_JAL:            nxt = JAL;
`endif
                    default:           nxt = FETCH;
                endcase
            end
            MEMADR: nxt = (bus.opcode == OP_LOAD) ? MEMRD : MEMWR;
            MEMRD:  nxt = bus.mem_ready ? MEMWB : MEMRD;
            MEMWR:  nxt = bus.mem_ready ? FETCH : MEMWR;
            EXEC:   nxt = ALUWB;
            EXECI:  nxt = ALUWB;
            // illegal encodings, and every final step, fall back to FETCH
            default: nxt = FETCH;
        endcase
    end

    mc_output_decode u_dec (
        .state     (state),
        .mem_ready (bus.mem_ready),
        .ctrl      (ctrl)
    );

    assign bus.pcwrite     = ctrl.pcwrite;
    assign bus.pcwritecond = ctrl.pcwritecond;
    assign bus.iord        = ctrl.iord;
    assign bus.memread     = ctrl.memread;
    assign bus.memwrite    = ctrl.memwrite;
    assign bus.irwrite     = ctrl.irwrite;
    assign bus.memtoreg    = ctrl.memtoreg;
    assign bus.pcsource    = ctrl.pcsource;
    assign bus.aluop       = ctrl.aluop;
    assign bus.alusrca     = ctrl.alusrca;
    assign bus.alusrcb     = ctrl.alusrcb;
    assign bus.regwrite    = ctrl.regwrite;
    assign bus.instr_done  = ctrl.instr_done | bad_op;
    assign bus.illegal     = illegal_q;

endmodule
